// File: rtl/xoro_pkg.sv
// Shared constants and types for the xoroshiro128+ UART streamer.
package xoro_pkg;

  localparam logic [63:0] SEED_S0_DEF = 64'h0000_0000_0000_0001;
  localparam logic [63:0] SEED_S1_DEF = 64'h0000_0000_0000_0002;

  localparam int unsigned ROT_A = 55;
  localparam int unsigned SHF_B = 14;
  localparam int unsigned ROT_C = 36;

  typedef enum logic {
    LOAD = 1'b0,
    RUN  = 1'b1
  } xoro_state_t;

  function automatic logic [63:0] rotl64(input logic [63:0] x, input int unsigned n);
    return (x << n) | (x >> (64 - n));
  endfunction

endpackage

// File: rtl/xoro_if.sv
// Byte handshake between the PRNG control and the UART transmitter.
interface xoro_if;
  logic [7:0] data;
  logic       start;
  logic       busy;
  logic       done;
  logic       tx;

  modport master (output data, output start, input busy, input done, input tx);
  modport slave  (input data, input start, output busy, output done, output tx);
endinterface

// File: rtl/xoro_uart_tx.sv
// 8N1 transmitter: start bit, 8 data bits LSB first, stop bit, BIT_CYC clocks each.
module xoro_uart_tx
  import xoro_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000,
  parameter int BAUD   = 115_200
) (
  input  logic   clk,
  input  logic   rst,
  xoro_if.slave  bus
);

  localparam int BIT_CYC = CLK_HZ / BAUD;
  localparam int CW      = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;

  logic [CW-1:0] cyc_cnt;
  logic [3:0]    bit_cnt;
  logic [9:0]    shreg;
  logic          busy_q;
  logic          tx_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q  <= 1'b0;
      tx_q    <= 1'b1;
      cyc_cnt <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
    end else if (!busy_q) begin
      if (bus.start) begin
        busy_q  <= 1'b1;
        shreg   <= {1'b1, bus.data, 1'b0};
        tx_q    <= 1'b0;
        bit_cnt <= 4'd9;
        cyc_cnt <= CW'(BIT_CYC - 1);
      end
    end else if (cyc_cnt != '0) begin
      cyc_cnt <= cyc_cnt - CW'(1);
    end else if (bit_cnt == 4'd0) begin
      busy_q <= 1'b0;
      tx_q   <= 1'b1;
    end else begin
      // shreg[0] is the bit on the line; shreg[1] is the one that follows
      shreg   <= shreg >> 1;
      tx_q    <= shreg[1];
      bit_cnt <= bit_cnt - 4'd1;
      cyc_cnt <= CW'(BIT_CYC - 1);
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = busy_q && (cyc_cnt == '0) && (bit_cnt == 4'd0);
  assign bus.tx   = tx_q;

endmodule

// File: rtl/xoro_top.sv
// xoroshiro128+ PRNG loaded from a 4-word seed ROM, low result byte streamed over UART.
//   state | meaning
//   LOAD  | copy seed ROM words 0..3 into s0/s1, one per cycle
//   RUN   | advance PRNG every cycle, feed UART whenever it is idle
module xoro_top
  import xoro_pkg::*;
#(
  parameter int          CLK_HZ  = 50_000_000,
  parameter int          BAUD    = 115_200,
  parameter logic [63:0] SEED_S0 = SEED_S0_DEF,
  parameter logic [63:0] SEED_S1 = SEED_S1_DEF
) (
  input  logic       CLOCK_50,
  input  logic       reset_btn,
  output logic [3:0] LED,
  output logic [3:0] RND_OUT,
  output logic       UART_TX
);

  logic        resetn;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  xoro_state_t state, state_nxt;
  logic [63:0] s0, s1, t, result, s0_nxt, s1_nxt;
  logic [3:0]  led_cnt;
  logic [3:0]  rnd_q;
  logic        tx_rst;

  xoro_if uart_bus ();

  always_ff @(posedge CLOCK_50) begin
    resetn <= ~reset_btn;
  end

  always_comb begin
    case (mem_addr[3:2])
      2'd0:    mem_rdata = SEED_S0[31:0];
      2'd1:    mem_rdata = SEED_S0[63:32];
      2'd2:    mem_rdata = SEED_S1[31:0];
      default: mem_rdata = SEED_S1[63:32];
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (!resetn) state <= LOAD;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      LOAD:    if (mem_addr[3:2] == 2'd3) state_nxt = RUN;
      RUN:     state_nxt = RUN;
      default: state_nxt = LOAD;
    endcase
  end

  always_comb begin
    result = s0 + s1;
    t      = s1 ^ s0;
    s0_nxt = rotl64(s0, ROT_A) ^ t ^ (t << SHF_B);
    s1_nxt = rotl64(t, ROT_C);
  end

  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      mem_addr <= '0;
      s0       <= '0;
      s1       <= '0;
      rnd_q    <= '0;
      led_cnt  <= '0;
    end else begin
      if (state == LOAD) begin
        case (mem_addr[3:2])
          2'd0:    s0[31:0]  <= mem_rdata;
          2'd1:    s0[63:32] <= mem_rdata;
          2'd2:    s1[31:0]  <= mem_rdata;
          default: s1[63:32] <= mem_rdata;
        endcase
        if (mem_addr[3:2] != 2'd3) mem_addr <= mem_addr + 32'd4;
      end else begin
        s0    <= s0_nxt;
        s1    <= s1_nxt;
        rnd_q <= result[3:0];
      end
      if (uart_bus.done) led_cnt <= led_cnt + 4'd1;
    end
  end

  // results produced while a frame is on the wire are simply dropped
  assign uart_bus.start = (state == RUN) && !uart_bus.busy;
  assign uart_bus.data  = result[7:0];
  assign tx_rst         = ~resetn;

  xoro_uart_tx #(
    .CLK_HZ (CLK_HZ),
    .BAUD   (BAUD)
  ) u_uart_tx (
    .clk (CLOCK_50),
    .rst (tx_rst),
    .bus (uart_bus)
  );

  // the line must idle high the moment resetn drops, even mid-frame
  assign UART_TX = resetn ? uart_bus.tx : 1'b1;
  assign LED     = led_cnt;
  assign RND_OUT = rnd_q;

endmodule

// File: tb/tb_xoro_top.sv
// Directed bench for xoro_top with a 4-clock bit period.
module tb_xoro_top;

  logic       clk = 1'b0;
  logic       reset_btn = 1'b1;
  logic [3:0] led;
  logic [3:0] rnd_out;
  logic       uart_tx;

  int tests  = 0;
  int failed = 0;

  localparam int          BIT_CYC   = 4;
  localparam int          FRAME_PER = 10 * BIT_CYC + 1;
  localparam logic [63:0] RES1      = 64'h0000_0000_0000_0003;
  localparam logic [63:0] RES2      = 64'h0080_0030_0000_C003;
  localparam logic [63:0] RES3      = 64'h0118_4060_3800_0363;

  xoro_if mon ();

  xoro_top #(
    .CLK_HZ (50_000_000),
    .BAUD   (12_500_000)
  ) dut (
    .CLOCK_50  (clk),
    .reset_btn (reset_btn),
    .LED       (led),
    .RND_OUT   (rnd_out),
    .UART_TX   (uart_tx)
  );

  assign mon.tx    = uart_tx;
  assign mon.busy  = dut.uart_bus.busy;
  assign mon.done  = dut.uart_bus.done;
  assign mon.start = dut.uart_bus.start;
  assign mon.data  = dut.uart_bus.data;

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // called one cycle before the posedge that releases reset
  task automatic check_load_run(input string sfx);
    logic [31:0] addr_exp [4];
    logic [31:0] data_exp [4];
    addr_exp = '{32'd0, 32'd4, 32'd8, 32'd12};
    data_exp = '{32'd1, 32'd0, 32'd2, 32'd0};
    for (int i = 0; i < 4; i++) begin
      tick();
      check_val($sformatf("mem_addr%0d%s", i, sfx), 64'(dut.mem_addr), 64'(addr_exp[i]));
      check_val($sformatf("mem_rdata%0d%s", i, sfx), 64'(dut.mem_rdata), 64'(data_exp[i]));
    end
    tick();
    check_val({"result1", sfx}, dut.result, RES1);
    check_val({"addr_hold", sfx}, 64'(dut.mem_addr), 64'd12);
    check_val({"tx_idle_run", sfx}, 64'(uart_tx), 64'd1);
    tick();
    check_val({"rnd1", sfx}, 64'(rnd_out), 64'd3);
    check_val({"result2", sfx}, dut.result, RES2);
    check_val({"tx_start", sfx}, 64'(uart_tx), 64'd0);
    tick();
    check_val({"rnd2", sfx}, 64'(rnd_out), 64'd3);
    check_val({"result3", sfx}, dut.result, RES3);
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] frame_exp;
    int         bad;
    int         waited;
    int         pos;
    frame_exp = {1'b1, 8'h03, 1'b0};

    reset_btn = 1'b1;
    tick(3);
    check_val("rst_resetn", 64'(dut.resetn), 64'd0);
    check_val("rst_tx", 64'(uart_tx), 64'd1);
    check_val("rst_led", 64'(led), 64'd0);
    check_val("rst_rnd", 64'(rnd_out), 64'd0);
    check_val("rst_addr", 64'(dut.mem_addr), 64'd0);

    reset_btn = 1'b0;
    check_load_run("");

    // now in the 2nd cycle of the start bit; sample each bit at the same phase
    for (int i = 0; i < 10; i++) begin
      check_val($sformatf("frame1_bit%0d", i), 64'(uart_tx), 64'(frame_exp[i]));
      if (i < 9) tick(BIT_CYC);
    end
    check_val("led_in_stop", 64'(led), 64'd0);

    waited = 0;
    while (mon.busy && waited < 10) begin
      tick();
      waited++;
    end
    check_val("frame1_ends", 64'(mon.busy), 64'd0);
    check_val("frame1_len", 64'(waited), 64'd3);
    check_val("led_after_1", 64'(led), 64'd1);
    check_val("idle_tx", 64'(uart_tx), 64'd1);

    // 15 more frames at a fixed 41-cycle cadence: pos 0 idle, 1..4 start, 37..40 stop
    bad = 0;
    for (int n = 0; n < 15 * FRAME_PER; n++) begin
      pos = n % FRAME_PER;
      if (pos == 0 && uart_tx !== 1'b1) bad++;
      if (pos >= 1 && pos <= BIT_CYC && uart_tx !== 1'b0) bad++;
      if (pos > 9 * BIT_CYC && uart_tx !== 1'b1) bad++;
      if (n == 14 * FRAME_PER) check_val("led_15", 64'(led), 64'd15);
      tick();
    end
    check_val("frame_shape_errs", 64'(bad), 64'd0);
    check_val("led_wrap", 64'(led), 64'd0);

    tick(2 * FRAME_PER);
    check_val("led_2", 64'(led), 64'd2);
    tick(2);
    check_val("mid_start_bit", 64'(uart_tx), 64'd0);

    reset_btn = 1'b1;
    tick();
    check_val("mid_rst_tx", 64'(uart_tx), 64'd1);
    tick();
    check_val("mid_rst_led", 64'(led), 64'd0);
    check_val("mid_rst_addr", 64'(dut.mem_addr), 64'd0);
    check_val("mid_rst_rnd", 64'(rnd_out), 64'd0);

    reset_btn = 1'b0;
    check_load_run("_re");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
